// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the fetch controller state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    function automatic logic stat_is_exc(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms for the fetch/pipeline controller.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       load_use,
    output logic       ret_pend,
    output logic       mispred,
    output logic       exc
);

    logic e_is_load;

    assign e_is_load = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);
    assign load_use  = e_is_load && (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    assign mispred   = (E_icode == IJXX) && !e_Cnd;
    assign exc       = stat_is_exc(m_stat) || stat_is_exc(W_stat);

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Y86-64 fetch PC sequencer and pipeline stall/bubble controller.
// Optional performance counters enabled by FETCH_PIPE_CTRL_PERF_EN.
module fetch_pipe_ctrl
    import y86_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] predPC,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      d_srcA,
    input  logic [3:0]      d_srcB,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_dstM,
    input  logic            e_Cnd,
    input  logic [3:0]      M_icode,
    input  logic            M_Cnd,
    input  logic [PC_W-1:0] M_valA,
    input  logic [2:0]      m_stat,
    input  logic [3:0]      W_icode,
    input  logic [PC_W-1:0] W_valM,
    input  logic [2:0]      W_stat,
`ifdef FETCH_PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt,
`endif
    output logic [PC_W-1:0] f_pc,
    output logic [PC_W-1:0] F_predPC,
    output logic            F_stall,
    output logic            D_stall,
    output logic            D_bubble,
    output logic            E_bubble,
    output logic            M_bubble,
    output logic            W_stall,
    output logic            halted
);

    logic            load_use;
    logic            ret_pend;
    logic            mispred;
    logic            exc;
    state_e          state_q;
    logic            halted_q;
    logic [PC_W-1:0] pred_pc_q;
    logic [PC_W-1:0] pred_pc_d;

    hazard_detect u_hazard_detect (
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .load_use (load_use),
        .ret_pend (ret_pend),
        .mispred  (mispred),
        .exc      (exc)
    );

    // Redirects are suppressed during reset so nothing in flight leaks out.
    always_comb begin
        f_pc = pred_pc_q;
        if (!rst) begin
            if ((M_icode == IJXX) && !M_Cnd) begin
                f_pc = M_valA;
            end else if (W_icode == IRET) begin
                f_pc = W_valM;
            end
        end
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        if (!rst) begin
            if (state_q == HALTED) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end else begin
                F_stall  = load_use || ret_pend;
                D_stall  = load_use;
                D_bubble = mispred || (ret_pend && !load_use);
                E_bubble = mispred || load_use;
                M_bubble = exc;
                W_stall  = (W_stat != SAOK);
            end
        end
    end

    assign pred_pc_d = F_stall ? pred_pc_q : predPC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            halted_q  <= 1'b0;
            pred_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                RUN: begin
                    pred_pc_q <= pred_pc_d;
                    if (W_stat != SAOK) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign F_predPC = pred_pc_q;
    assign halted   = halted_q;

`ifdef FETCH_PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] ret_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            mispred_cnt_q <= '0;
            ret_cnt_q     <= '0;
        end else if (state_q == RUN) begin
            stall_cnt_q   <= stall_cnt_q   + {{(CNT_W-1){1'b0}}, F_stall};
            mispred_cnt_q <= mispred_cnt_q + {{(CNT_W-1){1'b0}}, mispred};
            ret_cnt_q     <= ret_cnt_q     + {{(CNT_W-1){1'b0}}, (W_icode == IRET)};
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign ret_cnt     = ret_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed and randomized checks of fetch_pipe_ctrl against a cycle-level reference model.
module tb_fetch_pipe_ctrl;

    localparam int CW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] predPC;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic        e_Cnd, M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [2:0]  m_stat, W_stat;
    logic [63:0] f_pc, F_predPC;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
`ifdef FETCH_PIPE_CTRL_PERF_EN
    logic [CW-1:0] stall_cnt, mispred_cnt, ret_cnt;
`endif

    fetch_pipe_ctrl dut (
        .clk(clk), .rst(rst), .predPC(predPC),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA), .m_stat(m_stat),
        .W_icode(W_icode), .W_valM(W_valM), .W_stat(W_stat),
`ifdef FETCH_PIPE_CTRL_PERF_EN
        .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt),
`endif
        .f_pc(f_pc), .F_predPC(F_predPC),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [63:0] m_pred;
    bit          m_halt;
    bit          m_fstall, m_mp;
    int unsigned m_stall_cnt, m_mp_cnt, m_ret_cnt;

    wire [5:0] ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit bad_stat(input logic [2:0] s);
        return (s >= 3'd2) && (s <= 3'd4);
    endfunction

    task automatic check_all(input string tag);
        bit lu, rp, ex;
        logic [5:0]  e_ctrl;
        logic [63:0] e_pc;
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
        rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        m_mp = (E_icode == 4'h7) && (e_Cnd == 1'b0);
        ex = bad_stat(m_stat) || bad_stat(W_stat);
        if (rst) e_ctrl = 6'b0;
        else if (m_halt) e_ctrl = 6'b110111;
        else e_ctrl = {lu | rp, lu, m_mp | (rp & ~lu), m_mp | lu, ex, W_stat != 3'd1};
        m_fstall = e_ctrl[5];
        if (rst) e_pc = m_pred;
        else if (M_icode == 4'h7 && !M_Cnd) e_pc = M_valA;
        else if (W_icode == 4'h9) e_pc = W_valM;
        else e_pc = m_pred;
        chk({tag, ".ctrl"}, ctrl, e_ctrl);
        chk({tag, ".f_pc"}, f_pc, e_pc);
        chk({tag, ".F_predPC"}, F_predPC, m_pred);
        chk({tag, ".halted"}, halted, m_halt);
`ifdef FETCH_PIPE_CTRL_PERF_EN
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall_cnt);
        chk({tag, ".mispred_cnt"}, mispred_cnt, m_mp_cnt);
        chk({tag, ".ret_cnt"}, ret_cnt, m_ret_cnt);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst && !m_halt) begin
            if (!m_fstall) m_pred = predPC;
            m_stall_cnt += m_fstall;
            m_mp_cnt    += m_mp;
            m_ret_cnt   += (W_icode == 4'h9);
            if (W_stat != 3'd1) m_halt = 1;
        end
        #1;
    endtask

    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        advance();
    endtask

    task automatic model_reset();
        m_pred = 64'h0;
        m_halt = 0;
        m_stall_cnt = 0;
        m_mp_cnt = 0;
        m_ret_cnt = 0;
    endtask

    task automatic idle_inputs();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_Cnd = 1'b1; M_valA = 64'h0; W_valM = 64'h0;
        m_stat = 3'd1; W_stat = 3'd1;
    endtask

    function automatic logic [3:0] rand_icode();
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
                0: return 4'h5;
                1: return 4'hB;
                2: return 4'h7;
                default: return 4'h9;
            endcase
        end
        return 4'($urandom_range(0, 11));
    endfunction

    initial begin
        idle_inputs();
        predPC = 64'h10;
        rst = 1'b1;
        model_reset();
        #2;
        check_all("rst");
        chk("rst.F_predPC0", F_predPC, 64'h0);
        advance();
        cyc("rst_hold");
        rst = 1'b0;
        cyc("rst_release");
        chk("first.F_predPC", F_predPC, 64'h10);
        chk("first.f_pc", f_pc, 64'h10);

        // load-use
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; predPC = 64'h20;
        #1;
        chk("lu.ctrl", ctrl, 6'b110100);
        cyc("lu");
        chk("lu.hold", F_predPC, 64'h10);

        // load-use together with ret: stall, no bubble in D
        D_icode = 4'h9;
        #1;
        chk("lu_ret.ctrl", ctrl, 6'b110100);
        cyc("lu_ret");

        // mispredict
        D_icode = 4'h1; E_icode = 4'h7; e_Cnd = 1'b0; E_dstM = 4'hF; d_srcA = 4'hF;
        predPC = 64'h30;
        #1;
        chk("mp.ctrl", ctrl, 6'b001100);
        cyc("mp");
        chk("mp.F_predPC", F_predPC, 64'h30);
        E_icode = 4'h1; e_Cnd = 1'b1; M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h2A;
        #1;
        chk("mp_fix.f_pc", f_pc, 64'h2A);
        cyc("mp_fix");

        // ret walk through D, E, M then W
        M_icode = 4'h1; M_Cnd = 1'b1; D_icode = 4'h9;
        #1; chk("retD.ctrl", ctrl, 6'b101000); cyc("retD");
        D_icode = 4'h1; E_icode = 4'h9;
        #1; chk("retE.ctrl", ctrl, 6'b101000); cyc("retE");
        E_icode = 4'h1; M_icode = 4'h9;
        #1; chk("retM.ctrl", ctrl, 6'b101000); cyc("retM");
        M_icode = 4'h1; W_icode = 4'h9; W_valM = 64'h80;
        #1; chk("retW.f_pc", f_pc, 64'h80); chk("retW.ctrl", ctrl, 6'b0); cyc("retW");

        // exception then halt
        W_icode = 4'h1; m_stat = 3'd3;
        #1; chk("excM.ctrl", ctrl, 6'b000010); cyc("excM");
        chk("excM.halted", halted, 1'b0);
        m_stat = 3'd1; W_stat = 3'd3;
        #1; chk("excW.ctrl", ctrl, 6'b000011); cyc("excW");
        chk("excW.halted", halted, 1'b1);
        W_stat = 3'd1; predPC = 64'h999;
        for (int i = 0; i < 3; i++) begin
            #1; chk("halt.ctrl", ctrl, 6'b110111); cyc("halt");
        end
        chk("halt.persist", halted, 1'b1);
        rst = 1'b1; model_reset();
        #1; chk("halt_rst.halted", halted, 1'b0);
        cyc("halt_rst");
        rst = 1'b0;
        idle_inputs();

`ifdef FETCH_PIPE_CTRL_PERF_EN
        cyc("perf_start");
        rst = 1'b1; model_reset(); cyc("perf_rst"); rst = 1'b0;
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; cyc("perf_lu");
        E_icode = 4'h1; E_dstM = 4'hF; d_srcB = 4'hF; D_icode = 4'h9; cyc("perf_rd");
        D_icode = 4'h1; E_icode = 4'h9; cyc("perf_re");
        E_icode = 4'h1; M_icode = 4'h9; cyc("perf_rm");
        M_icode = 4'h1;
        #1;
        chk("perf.stall_cnt", stall_cnt, 32'd4);
        chk("perf.mispred_cnt", mispred_cnt, 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            predPC  = {$urandom, $urandom};
            D_icode = rand_icode();
            E_icode = rand_icode();
            M_icode = rand_icode();
            W_icode = rand_icode();
            E_dstM  = 4'($urandom_range(0, 15));
            d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            e_Cnd   = 1'($urandom);
            M_Cnd   = 1'($urandom);
            M_valA  = {$urandom, $urandom};
            W_valM  = {$urandom, $urandom};
            m_stat  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            W_stat  = ($urandom_range(0, 40) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            if ((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 70) == 0) begin
                rst = 1'b1;
                model_reset();
                cyc("rnd_rst");
                rst = 1'b0;
            end else begin
                cyc("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
